// File: rtl/rc_pkg.sv
// rc_pkg -- shared definitions for the serial ripple-carry adder (rc_serial).
//   state_t   : controller state encoding (IDLE / RUN / DONE)
//   clog2     : counter width helper, never returns less than 1
//   width_ok  : legality check for the W / K parameter pair
package rc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to count 0..n-1; a single-slice adder still gets a 1-bit counter.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // The operand must split into a whole number of K-bit slices.
  function automatic bit width_ok(input int w, input int k);
    return (w >= 1) && (k >= 1) && ((w % k) == 0);
  endfunction

endpackage

// File: rtl/rc_slice.sv
// rc_slice -- combinational K-bit ripple-carry slice built from rc-style
// generate (a & b) and propagate (a | b) terms.
// Ports:
//   a, b   : K-bit operand slices
//   ci     : carry into bit 0 of the slice
//   sum    : K-bit slice sum
//   co     : carry out of bit K-1
//   c_msb  : carry into bit K-1 (needed for signed overflow on the top slice)
module rc_slice #(
  parameter int K = 1
) (
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  input  logic         ci,
  output logic [K-1:0] sum,
  output logic         co,
  output logic         c_msb
);

  logic [K-1:0] g;
  logic [K-1:0] p;
  logic [K:0]   c;

  assign g    = a & b;
  assign p    = a | b;
  assign c[0] = ci;

  for (genvar i = 0; i < K; i++) begin : g_bit
    assign c[i+1] = g[i] | (p[i] & c[i]);
    assign sum[i] = a[i] ^ b[i] ^ c[i];
  end

  assign co    = c[K];
  assign c_msb = c[K-1];

endmodule

// File: rtl/rc_serial.sv
// rc_serial -- multi-cycle W-bit adder, K bits per clock, LSB slice first,
// with a start/busy/done handshake.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   start        : request, only looked at in IDLE
//   x, y, cin    : operands, captured when start is accepted
//   busy         : high whenever the controller is not IDLE
//   done         : one-cycle pulse when s/cout hold a fresh result
//   s, cout      : registered sum and carry-out, held until the next result
//   ovf          : signed overflow, present only when RC_SERIAL_OVF_EN is defined
module rc_serial
  import rc_pkg::*;
#(
  parameter int W = 8,
  parameter int K = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] s,
  output logic         cout
`ifdef RC_SERIAL_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int N  = W / K;
  localparam int CW = clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (!width_ok(W, K)) begin : g_bad_width
    $error("rc_serial: W must be a positive multiple of K");
  end

  state_t        state;
  state_t        state_nxt;
  logic [W-1:0]  xs;
  logic [W-1:0]  ys;
  logic [W-1:0]  sum_sr;
  logic [W-1:0]  sum_full;
  logic          carry;
  logic [CW-1:0] cnt;
  logic [K-1:0]  slice_sum;
  logic          slice_co;
  logic          slice_cmsb;
  logic          last;

  rc_slice #(.K(K)) u_slice (
    .a     (xs[K-1:0]),
    .b     (ys[K-1:0]),
    .ci    (carry),
    .sum   (slice_sum),
    .co    (slice_co),
    .c_msb (slice_cmsb)
  );

  assign last = (cnt == LAST);

  // New slice enters at the top; after N shifts the sum is LSB-aligned.
  if (N == 1) begin : g_one_slice
    assign sum_full = slice_sum;
  end else begin : g_multi_slice
    assign sum_full = {slice_sum, sum_sr[W-1:K]};
  end

  // The lowest slice of sum_sr is shifted out without being read.
  logic [K-1:0] unused_sr_low;
  assign unused_sr_low = sum_sr[K-1:0];

`ifndef RC_SERIAL_OVF_EN
  logic unused_cmsb;
  assign unused_cmsb = slice_cmsb;
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      xs     <= '0;
      ys     <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      s      <= '0;
      cout   <= 1'b0;
`ifdef RC_SERIAL_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            xs    <= x;
            ys    <= y;
            carry <= cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          xs     <= xs >> K;
          ys     <= ys >> K;
          carry  <= slice_co;
          sum_sr <= sum_full;
          cnt    <= cnt + 1'b1;
          if (last) begin
            s    <= sum_full;
            cout <= slice_co;
`ifdef RC_SERIAL_OVF_EN
            // Top slice: carry into the MSB differs from carry out on signed overflow.
            ovf  <= slice_cmsb ^ slice_co;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rc_serial.sv
module tb_rc_serial;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start1 = 1'b0;
  logic       start4 = 1'b0;
  logic [7:0] x = 8'h00;
  logic [7:0] y = 8'h00;
  logic       cin = 1'b0;

  logic       busy1, done1, cout1;
  logic [7:0] s1;
  logic       busy4, done4, cout4;
  logic [7:0] s4;
`ifdef RC_SERIAL_OVF_EN
  logic       ovf1, ovf4;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] last_s1 = 8'h00;

  typedef struct {
    logic [7:0] s;
    logic       cout;
    logic       ovf;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  exp_t m1, m4;

  rc_serial #(.W(8), .K(1)) dut1 (
    .clock (clock), .reset (reset), .start (start1),
    .x (x), .y (y), .cin (cin),
    .busy (busy1), .done (done1), .s (s1), .cout (cout1)
`ifdef RC_SERIAL_OVF_EN
    , .ovf (ovf1)
`endif
  );

  rc_serial #(.W(8), .K(4)) dut4 (
    .clock (clock), .reset (reset), .start (start4),
    .x (x), .y (y), .cin (cin),
    .busy (busy4), .done (done4), .s (s4), .cout (cout4)
`ifdef RC_SERIAL_OVF_EN
    , .ovf (ovf4)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic c);
    exp_t e;
    logic [8:0] t;
    t = {1'b0, a} + {1'b0, b} + {8'b0, c};
    e.s = t[7:0];
    e.cout = t[8];
    e.ovf = (a[7] == b[7]) && (t[7] != a[7]);
    return e;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding operation.
  always @(negedge clock) begin
    if (done1 === 1'b1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL sb1_unexpected_done got s=%h cout=%b, required no done", s1, cout1);
      end else begin
        m1 = q1.pop_front();
        if ({s1, cout1} !== {m1.s, m1.cout}) begin
          errors++;
          $display("FAIL sb1_result got s=%h cout=%b, required s=%h cout=%b", s1, cout1, m1.s, m1.cout);
        end
`ifdef RC_SERIAL_OVF_EN
        checks++;
        if (ovf1 !== m1.ovf) begin
          errors++;
          $display("FAIL sb1_ovf got %b, required %b", ovf1, m1.ovf);
        end
`endif
      end
    end
  end

  always @(negedge clock) begin
    if (done4 === 1'b1) begin
      checks++;
      if (q4.size() == 0) begin
        errors++;
        $display("FAIL sb4_unexpected_done got s=%h cout=%b, required no done", s4, cout4);
      end else begin
        m4 = q4.pop_front();
        if ({s4, cout4} !== {m4.s, m4.cout}) begin
          errors++;
          $display("FAIL sb4_result got s=%h cout=%b, required s=%h cout=%b", s4, cout4, m4.s, m4.cout);
        end
`ifdef RC_SERIAL_OVF_EN
        checks++;
        if (ovf4 !== m4.ovf) begin
          errors++;
          $display("FAIL sb4_ovf got %b, required %b", ovf4, m4.ovf);
        end
`endif
      end
    end
  end

  // One operation on dut1 (sel=0, N=8) or dut4 (sel=1, N=2); checks handshake timing.
  task automatic run_op(input bit sel, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input string tag);
    int n;
    int busy_cnt;
    int done_at;
    exp_t e;
    n = sel ? 2 : 8;
    busy_cnt = 0;
    done_at = 0;
    e = model(a, b, c);
    x = a; y = b; cin = c;
    if (sel) begin start4 = 1'b1; q4.push_back(e); end
    else begin start1 = 1'b1; q1.push_back(e); last_s1 = e.s; end
    @(posedge clock); #1;
    start1 = 1'b0; start4 = 1'b0;
    x = ~a; y = ~b; cin = ~c;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if ((sel ? busy4 : busy1) === 1'b1) busy_cnt++;
      if ((sel ? done4 : done1) === 1'b1) begin
        done_at = i;
        break;
      end
    end
    checks++;
    if (done_at != n + 1) begin
      errors++;
      $display("FAIL %s_done_latency got cycle %0d, required %0d", tag, done_at, n + 1);
    end
    checks++;
    if (busy_cnt != n + 1) begin
      errors++;
      $display("FAIL %s_busy_cycles got %0d, required %0d", tag, busy_cnt, n + 1);
    end
    @(posedge clock); #1;
    checks++;
    if ((sel ? busy4 : busy1) !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_after got busy=%b, required 0", tag, sel ? busy4 : busy1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({busy1, done1, s1, cout1} !== 11'd0) begin
      errors++;
      $display("FAIL reset_k1 got busy=%b done=%b s=%h cout=%b, required all 0", busy1, done1, s1, cout1);
    end
    checks++;
    if ({busy4, done4, s4, cout4} !== 11'd0) begin
      errors++;
      $display("FAIL reset_k4 got busy=%b done=%b s=%h cout=%b, required all 0", busy4, done4, s4, cout4);
    end
`ifdef RC_SERIAL_OVF_EN
    checks++;
    if ({ovf1, ovf4} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ovf got %b%b, required 00", ovf1, ovf4);
    end
`endif
    reset = 1'b0;
  endtask

  task automatic test_k1_add();
    run_op(1'b0, 8'h00, 8'h00, 1'b0, "k1_zero");
    run_op(1'b0, 8'hFF, 8'h01, 1'b0, "k1_wrap");
    run_op(1'b0, 8'h0F, 8'hF0, 1'b1, "k1_cin");
  endtask

  task automatic test_k4_add();
    run_op(1'b1, 8'hA5, 8'h5A, 1'b1, "k4_carry");
    run_op(1'b1, 8'h12, 8'h34, 1'b0, "k4_plain");
  endtask

  // start held high; operands scrambled right after each acceptance.
  task automatic test_back_to_back();
    logic [7:0] ax[3] = '{8'h11, 8'h80, 8'h3C};
    logic [7:0] ay[3] = '{8'h22, 8'h80, 8'h0A};
    logic       ac[3] = '{1'b0, 1'b1, 1'b1};
    int prev_done;
    int done_at;
    exp_t e;
    prev_done = 0;
    for (int i = 0; i < 3; i++) begin
      x = ax[i]; y = ay[i]; cin = ac[i];
      start1 = 1'b1;
      e = model(ax[i], ay[i], ac[i]);
      q1.push_back(e);
      @(posedge clock); #1;
      x = 8'($urandom); y = 8'($urandom); cin = 1'($urandom);
      done_at = 0;
      for (int j = 1; j <= 40; j++) begin
        @(negedge clock);
        if (j == 4) begin
          checks++;
          if (s1 !== last_s1) begin
            errors++;
            $display("FAIL b2b_s_hold got s=%h, required %h", s1, last_s1);
          end
        end
        if (done1 === 1'b1) begin
          done_at = cyc;
          break;
        end
      end
      checks++;
      if (done_at == 0) begin
        errors++;
        $display("FAIL b2b_timeout got no done, required done within 40 cycles");
      end else if (i > 0 && (done_at - prev_done) != 10) begin
        errors++;
        $display("FAIL b2b_spacing got %0d cycles, required 10", done_at - prev_done);
      end
      prev_done = done_at;
      last_s1 = e.s;
      @(posedge clock); #1;
    end
    start1 = 1'b0;
  endtask

  task automatic test_abort();
    x = 8'h55; y = 8'h66; cin = 1'b0;
    start1 = 1'b1;
    @(posedge clock); #1;
    start1 = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    checks++;
    if ({busy1, done1} !== 2'b10) begin
      errors++;
      $display("FAIL abort_mid_run got busy=%b done=%b, required busy=1 done=0", busy1, done1);
    end
    @(posedge clock); #1;
    checks++;
    if ({busy1, done1, s1, cout1} !== 11'd0) begin
      errors++;
      $display("FAIL abort_cleared got busy=%b done=%b s=%h cout=%b, required all 0", busy1, done1, s1, cout1);
    end
    reset = 1'b0;
    run_op(1'b0, 8'h03, 8'h04, 1'b0, "abort_fresh");
  endtask

  task automatic test_signed_ovf();
    run_op(1'b0, 8'h7F, 8'h01, 1'b0, "ovf_pos");
    run_op(1'b0, 8'hFF, 8'h01, 1'b0, "ovf_none");
    run_op(1'b1, 8'h7F, 8'h01, 1'b0, "ovf_k4_pos");
    run_op(1'b1, 8'h80, 8'hFF, 1'b0, "ovf_k4_neg");
  endtask

  initial begin
    test_reset();
    test_k1_add();
    test_k4_add();
    test_back_to_back();
    test_abort();
    test_signed_ovf();
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (q1.size() + q4.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d outstanding, required 0", q1.size() + q4.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
